// File: rtl/rwc_challenger.sv
// rwc_challenger: issues LFSR challenges to rwc_ctrl over an address range and streams collision signatures.
// Ports: clk/rst (sync, active-high); start/base_addr/num_cha/seed run request; busy/done/err status;
//        gen_enable/cha_data/cha_addr/available controller handshake; rsp_write/rsp_clean controller
//        responses; rsp_valid/rsp_ready/rsp_addr/rsp_data/rsp_raw upstream result stream.
module rwc_challenger #(
    parameter int          TIMEOUT_CYCLES = 64,
    parameter logic [31:0] LFSR_DEFAULT   = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [9:0]  base_addr,
    input  logic [10:0] num_cha,
    input  logic [31:0] seed,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        gen_enable,
    output logic [31:0] cha_data,
    output logic [9:0]  cha_addr,
    input  logic        available,
    input  logic [31:0] rsp_write,
    input  logic [31:0] rsp_clean,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [9:0]  rsp_addr,
    output logic [31:0] rsp_data,
    output logic [63:0] rsp_raw
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, OUTPUT, FINISH} state_t;

    state_t        state_q, state_d;
    logic [31:0]   lfsr_q, lfsr_d, wr_q, wr_d, cl_q, cl_d;
    logic [9:0]    addr_q, addr_d;
    logic [10:0]   rem_q, rem_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          err_q, err_d, gen_q, gen_d;
    logic          tmo, drive;

    assign tmo = tmr_q == TW'(TIMEOUT_CYCLES - 1);

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        wr_d    = wr_q;
        cl_d    = cl_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        tmr_d   = '0;
        err_d   = err_q;
        gen_d   = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                addr_d  = base_addr;
                rem_d   = num_cha;
                lfsr_d  = (seed == 32'd0) ? LFSR_DEFAULT : seed;
                err_d   = 1'b0;
                state_d = (num_cha == 11'd0) ? FINISH : ISSUE;
            end
            ISSUE: if (available) begin
                gen_d   = 1'b1;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                tmr_d = tmr_q + TW'(1);
                if (!available) begin
                    tmr_d   = '0;
                    state_d = WAIT_DONE;
                end else if (tmo) begin
                    err_d   = 1'b1;
                    state_d = FINISH;
                end
            end
            WAIT_DONE: begin
                tmr_d = tmr_q + TW'(1);
                if (available) begin
                    wr_d    = rsp_write;
                    cl_d    = rsp_clean;
                    state_d = OUTPUT;
                end else if (tmo) begin
                    err_d   = 1'b1;
                    state_d = FINISH;
                end
            end
            OUTPUT: if (rsp_ready) begin
                lfsr_d  = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
                addr_d  = addr_q + 10'd1;
                rem_d   = rem_q - 11'd1;
                state_d = (rem_q == 11'd1) ? FINISH : ISSUE;
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            lfsr_q  <= LFSR_DEFAULT;
            wr_q    <= '0;
            cl_q    <= '0;
            addr_q  <= '0;
            rem_q   <= '0;
            tmr_q   <= '0;
            err_q   <= 1'b0;
            gen_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            wr_q    <= wr_d;
            cl_q    <= cl_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            tmr_q   <= tmr_d;
            err_q   <= err_d;
            gen_q   <= gen_d;
        end
    end

    // Challenge is held on the bus for the whole ISSUE..WAIT_DONE window (BRAM address path is combinational).
    assign drive      = (state_q == ISSUE) || (state_q == WAIT_BUSY) || (state_q == WAIT_DONE);
    assign busy       = state_q != IDLE;
    assign done       = state_q == FINISH;
    assign err        = err_q;
    assign gen_enable = gen_q;
    assign cha_data   = drive ? lfsr_q : '0;
    assign cha_addr   = drive ? addr_q : '0;
    assign rsp_valid  = state_q == OUTPUT;
    assign rsp_addr   = rsp_valid ? addr_q : '0;
    assign rsp_data   = rsp_valid ? (wr_q ^ cl_q) : '0;
    assign rsp_raw    = rsp_valid ? {wr_q, cl_q} : '0;
endmodule

// File: tb/tb_rwc_challenger.sv
// tb_rwc_challenger: table-driven check of rwc_challenger against a small rwc_ctrl behavioural model.
module tb_rwc_challenger;
    localparam int T = 64;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, rsp_ready = 1'b0;
    logic [9:0]  base_addr = '0;
    logic [10:0] num_cha = '0;
    logic [31:0] seed = '0;
    logic        available = 1'b1;
    logic [31:0] rsp_write = '0, rsp_clean = '0;
    logic        busy, done, err, gen_enable, rsp_valid;
    logic [31:0] cha_data, rsp_data;
    logic [9:0]  cha_addr, rsp_addr;
    logic [63:0] rsp_raw;

    int n_cmp = 0, n_bad = 0;
    bit stuck = 1'b0, hold_low = 1'b0, mbusy = 1'b0;
    int lat = 2, mcnt = 0;

    always #5 clk = ~clk;

    rwc_challenger #(.TIMEOUT_CYCLES(T), .LFSR_DEFAULT(32'h0000_0001)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_cha(num_cha), .seed(seed),
        .busy(busy), .done(done), .err(err), .gen_enable(gen_enable), .cha_data(cha_data),
        .cha_addr(cha_addr), .available(available), .rsp_write(rsp_write), .rsp_clean(rsp_clean),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
        .rsp_raw(rsp_raw)
    );

    function automatic logic [31:0] step(input logic [31:0] d);
        return {d[30:0], d[31] ^ d[21] ^ d[1] ^ d[0]};
    endfunction
    function automatic logic [31:0] mw(input logic [31:0] d, input logic [9:0] a);
        return d ^ 32'hA5A5_0000 ^ {22'd0, a};
    endfunction
    function automatic logic [31:0] mc(input logic [31:0] d);
        return {d[15:0], d[31:16]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Controller model: drops available after a gen_enable pulse, raises it again lat cycles later with responses.
    always begin
        @(posedge clk);
        #1;
        if (rst) begin
            available = 1'b1;
            mbusy = 1'b0;
        end else if (hold_low) available = 1'b0;
        else if (mbusy) begin
            if (mcnt == 0) begin
                rsp_write = mw(cha_data, cha_addr);
                rsp_clean = mc(cha_data);
                available = 1'b1;
                mbusy = 1'b0;
            end else mcnt--;
        end else if (gen_enable && !stuck) begin
            available = 1'b0;
            mcnt = lat;
            mbusy = 1'b1;
        end else available = 1'b1;
    end

    typedef struct {
        logic [9:0]  b;
        logic [10:0] n;
        logic [31:0] s;
        int          hold;
        int          lat;
        bit          stuck;
        bit          eerr;
    } vec_t;

    task automatic run(input vec_t t);
        logic [31:0] l;
        logic [9:0]  a;
        int gens, outs, hc, cyc, gcyc;
        bit fin;
        l = (t.s == 32'd0) ? 32'h0000_0001 : t.s;
        a = t.b;
        gens = 0; outs = 0; hc = 0; cyc = 0; gcyc = 0; fin = 1'b0;
        lat = t.lat;
        stuck = t.stuck;
        rsp_ready = (t.hold == 0);
        @(negedge clk);
        base_addr = t.b; num_cha = t.n; seed = t.s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_rise", {63'd0, busy}, 64'd1);
        chk("err_clear_on_start", {63'd0, err}, 64'd0);
        while (!fin && cyc < 20000) begin
            if (gen_enable) begin
                gens++;
                gcyc = cyc;
                chk("cha_addr", {54'd0, cha_addr}, {54'd0, a});
                chk("cha_data", {32'd0, cha_data}, {32'd0, l});
                chk("gen_while_valid", {63'd0, rsp_valid}, 64'd0);
            end
            if (rsp_valid) begin
                chk("rsp_addr", {54'd0, rsp_addr}, {54'd0, a});
                chk("rsp_data", {32'd0, rsp_data}, {32'd0, mw(l, a) ^ mc(l)});
                chk("rsp_raw", rsp_raw, {mw(l, a), mc(l)});
                if (hc < t.hold) begin
                    rsp_ready = 1'b0;
                    hc++;
                end else begin
                    rsp_ready = 1'b1;
                    hc = 0;
                    outs++;
                    l = step(l);
                    a = a + 10'd1;
                end
            end else rsp_ready = (t.hold == 0);
            if (done) begin
                fin = 1'b1;
                chk("done_with_valid", {63'd0, rsp_valid}, 64'd0);
                chk("words_out", 64'(outs), t.eerr ? 64'd0 : 64'(t.n));
                chk("gen_pulses", 64'(gens), t.eerr ? 64'd1 : 64'(t.n));
                chk("err_at_done", {63'd0, err}, {63'd0, t.eerr});
                if (t.eerr) chk("timeout_latency", 64'(cyc - gcyc), 64'(T));
                if (t.n == 11'd0) chk("num0_done_lat", 64'(cyc), 64'd0);
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!fin) chk("done_seen", 64'd0, 64'd1);
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("done_one_cycle", {63'd0, done}, 64'd0);
        chk("idle_after_run", {63'd0, busy}, 64'd0);
    endtask

    vec_t v[8];

    initial begin
        int gens, dn;
        bit fin;
        v[0] = '{10'd5,    11'd1,    32'hDEAD_BEEF, 0,  3, 1'b0, 1'b0};
        v[1] = '{10'd1022, 11'd4,    32'h1234_5678, 0,  2, 1'b0, 1'b0};
        v[2] = '{10'd100,  11'd2,    32'hCAFE_F00D, 10, 4, 1'b0, 1'b0};
        v[3] = '{10'd7,    11'd1,    32'hAAAA_5555, 0,  0, 1'b1, 1'b1};
        v[4] = '{10'd3,    11'd2,    32'h0000_0000, 0,  1, 1'b0, 1'b0};
        v[5] = '{10'd0,    11'd0,    32'h0000_1234, 0,  1, 1'b0, 1'b0};
        v[6] = '{10'd1000, 11'd30,   32'h8000_0001, 1,  0, 1'b0, 1'b0};
        v[7] = '{10'd0,    11'd1024, 32'h1357_9BDF, 0,  1, 1'b0, 1'b0};

        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        chk("rst_gen", {63'd0, gen_enable}, 64'd0);
        chk("rst_cha_data", {32'd0, cha_data}, 64'd0);
        chk("rst_cha_addr", {54'd0, cha_addr}, 64'd0);
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_rsp_addr", {54'd0, rsp_addr}, 64'd0);
        chk("rst_rsp_data", {32'd0, rsp_data}, 64'd0);
        chk("rst_rsp_raw", rsp_raw, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run(v[i]);

        // ISSUE must not pulse while available is low.
        hold_low = 1'b1;
        lat = 1;
        rsp_ready = 1'b1;
        @(negedge clk);
        base_addr = 10'd9; num_cha = 11'd1; seed = 32'h0BAD_F00D; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("issue_hold_gen", {63'd0, gen_enable}, 64'd0);
            chk("issue_hold_addr", {54'd0, cha_addr}, 64'd9);
            @(negedge clk);
        end
        hold_low = 1'b0;
        gens = 0;
        fin = 1'b0;
        for (int i = 0; i < 50 && !fin; i++) begin
            if (gen_enable) gens++;
            if (done) fin = 1'b1;
            else @(negedge clk);
        end
        chk("issue_hold_done", {63'd0, fin}, 64'd1);
        chk("issue_hold_gens", 64'(gens), 64'd1);
        chk("issue_hold_err", {63'd0, err}, 64'd0);
        rsp_ready = 1'b0;
        @(negedge clk);

        // Reset during WAIT_DONE.
        lat = 8;
        base_addr = 10'd20; num_cha = 11'd1; seed = 32'h0F0F_1234; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        fin = 1'b0;
        for (int i = 0; i < 20 && !fin; i++) begin
            if (gen_enable) fin = 1'b1;
            else @(negedge clk);
        end
        chk("midrst_gen_seen", {63'd0, fin}, 64'd1);
        repeat (3) @(negedge clk);
        chk("midrst_waiting", {63'd0, available}, 64'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_gen", {63'd0, gen_enable}, 64'd0);
        chk("midrst_cha_addr", {54'd0, cha_addr}, 64'd0);
        chk("midrst_cha_data", {32'd0, cha_data}, 64'd0);
        chk("midrst_valid", {63'd0, rsp_valid}, 64'd0);
        chk("midrst_err", {63'd0, err}, 64'd0);
        chk("midrst_rsp", {rsp_data, 22'd0, rsp_addr}, 64'd0);
        chk("midrst_raw", rsp_raw, 64'd0);
        dn = 0;
        for (int i = 0; i < 15; i++) begin
            if (done) dn++;
            @(negedge clk);
        end
        chk("midrst_no_done", 64'(dn), 64'd0);
        run(v[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
